clock_gated_mult_seq: RTL
=========================

CLOCK_GATED_MULT_SEQ -- requirements
Module: clock_gated_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter TRUNC, default 4, number of result LSBs forced to zero per partial product in approximate mode (legal 0..2*WIDTH-1).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  clock-gate enable; low freezes all state.
REQ-006 SHALL have port start  input  1  request to launch a multiply.
REQ-007 SHALL have port A  input  WIDTH  unsigned multiplicand.
REQ-008 SHALL have port B  input  WIDTH  unsigned multiplier.
REQ-009 SHALL have port approx  input  1  approximate-mode select, present only when APPROX_MODE_EN is defined.
REQ-010 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Y  output  2*WIDTH  registered product.

Function
REQ-013 SHALL implement FSM states IDLE and RUN.
- IDLE->RUN on an edge with en=1, start=1.
- RUN->IDLE on the edge processing bit WIDTH-1.
REQ-014 SHALL, on acceptance at edge k:
- latch A, B (and approx);
- clear accumulator and bit counter;
- set busy=1.
REQ-015 SHALL, in RUN on each edge with en=1:
- add (A_reg << cnt) to the 2*WIDTH-bit accumulator when B_reg[cnt]=1;
- increment cnt;
- carry out of bit 2*WIDTH-1 is impossible and not kept.
REQ-016 SHALL, on the edge processing bit WIDTH-1 (edge k+WIDTH when en stays high):
- load Y with the final sum;
- set done=1, busy=0.
REQ-017 SHALL hold done high for exactly one enabled cycle, clearing it on the next edge with en=1.
REQ-018 SHALL hold Y unchanged until the next completion.
REQ-019 SHALL ignore start while busy=1; operands are taken only at acceptance.
REQ-020 SHALL, on every edge with en=0 and rst=1, hold all registers (state, cnt, accumulator, operands, Y, busy, done); latency stretches by the number of disabled cycles.
REQ-021 SHALL ignore start on an edge with en=0.
REQ-022 SHALL accept start in the same cycle done=1 (back-to-back): done clears, busy sets.

Reset
REQ-023 SHALL, at a clk edge with rst=0 and regardless of en:
- go to IDLE;
- clear cnt, accumulator and operand registers;
- drive busy=0, done=0, Y=0.
REQ-024 SHALL abort an in-progress multiply on reset without producing done; Y stays 0 afterwards until a new completion.

Configuration
REQ-025 SHALL, with APPROX_MODE_EN defined, add the approx port.
- When approx was latched as 1, each added partial product has its low TRUNC bits masked to zero before accumulation.
- When approx was latched as 0, the result is exact.
REQ-026 SHALL, with APPROX_MODE_EN undefined, omit the approx port and masking logic, always producing the exact product.

Verification
REQ-027 SHALL cover exact products, WIDTH=8:
- A=10, B=5, start -> done 8 edges later, Y=50;
- then 25x4 -> Y=100;
- then 255x255 -> Y=65025.
REQ-028 SHALL cover clock gating: start 12x12, drop en for 2 cycles mid-RUN -> busy held, done after 10 edges, Y=144; start with en=0 -> no acceptance.
REQ-029 SHALL cover start during busy: 50x10 running, start with 3x3 -> ignored, Y=500.
REQ-030 SHALL cover reset mid-operation: rst=0 at the 4th RUN edge -> busy=0, done=0, Y=0, no done pulse follows.
REQ-031 SHALL cover approximate mode (APPROX_MODE_EN, TRUNC=4): approx=1, A=10, B=5 -> Y=32; approx=0 -> Y=50.
REQ-032 SHALL cover back-to-back: start asserted with done -> second product 7x9=63 completes 8 edges later.

Source files
------------

// File: rtl/clock_gated_mult_seq.sv
// Sequential shift-add multiplier (one multiplier bit per enabled cycle) with a clock-gate enable.
// Define APPROX_MODE_EN to add the approx port: partial products then lose their low TRUNC bits.
module clock_gated_mult_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef APPROX_MODE_EN
  input  logic               approx,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Y
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [PW-1:0]   acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   y_q;
  logic            busy_q;
  logic            done_q;
`ifdef APPROX_MODE_EN
  logic            approx_q;
`endif

  logic [PW-1:0] shifted;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum;

  always_comb begin
    shifted = {{WIDTH{1'b0}}, a_q} << cnt_q;
    pp      = b_q[cnt_q] ? shifted : '0;
`ifdef APPROX_MODE_EN
    if (approx_q) pp = pp & ({PW{1'b1}} << TRUNC);
`endif
    // Operands fit in PW bits, so the carry out of the top bit is never needed.
    sum = acc_q + pp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef APPROX_MODE_EN
      approx_q <= 1'b0;
`endif
    end else if (en) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
`ifdef APPROX_MODE_EN
            approx_q <= approx;
`endif
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q <= sum;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            y_q     <= sum;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;

endmodule
